ps2_rx_frame: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_input_filter.sv | 61 ++++++
 rtl/ps2_rx_frame.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  // Deframer states: wait for start bit, shift data, capture parity, check stop.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Scan-code prefixes: extended key and key release.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Odd parity holds when data and parity bit together carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronises and debounces the raw PS/2 lines and marks kclk falling edges.
module ps2_input_filter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kclk,
  input  logic kdata,
  output logic fall_stb,
  output logic bit_val
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  // Index 0 is kclk, index 1 is kdata; both lines get identical treatment.
  logic [1:0]         s1_q, s2_q;
  logic [1:0]         filt_q, filt_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic               kclk_prev_q;

  // Filtered level flips only after the synchronised level disagrees for DB_MAX cycles in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] + CW'(1) >= DB_MAX) begin
          filt_d[i] = s2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i]  = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Two-flop synchronisers, debounce state and edge-detect history; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 2'b11;
      s2_q        <= 2'b11;
      filt_q      <= 2'b11;
      cnt_q       <= '0;
      kclk_prev_q <= 1'b1;
    end else begin
      s1_q        <= {kdata, kclk};
      s2_q        <= s1_q;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      kclk_prev_q <= filt_q[0];
    end
  end

  // Data is sampled on the filtered clock's falling edge; both lines share the same filter delay.
  assign fall_stb = kclk_prev_q & ~filt_q[0];
  assign bit_val  = filt_q[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard receiver: deframes 11-bit frames, hands bytes over valid/ready,
// keeps a byte history and turns E0/F0 prefixed scan codes into key events.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int HIST_BYTES      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    kclk,
  input  logic                    kdata,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [8*HIST_BYTES-1:0] hist,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_break,
  output logic                    key_valid,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    overrun
);

  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam int             DATA_BITS = FRAME_BITS - 3;
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  logic fall_stb, bit_val;

  ps2_input_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .kclk     (kclk),
    .kdata    (kdata),
    .fall_stb (fall_stb),
    .bit_val  (bit_val)
  );

  ps2_state_e              state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shift_q, shift_d;
  logic                    par_q, par_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    ext_q, ext_d;
  logic                    brk_q, brk_d;
  logic [7:0]              byte_data_q, byte_data_d;
  logic                    byte_valid_q, byte_valid_d;
  logic [8*HIST_BYTES-1:0] hist_q, hist_d;
  logic [7:0]              key_code_q, key_code_d;
  logic                    key_ext_q, key_ext_d;
  logic                    key_break_q, key_break_d;
  logic                    key_valid_q, key_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    parity_err_q, parity_err_d;
  logic                    overrun_q, overrun_d;
  logic                    good_stb;

  // Deframer: walks start/data/parity/stop on each kclk fall and aborts on inactivity.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_d        = '0;
    good_stb     = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    // Inactivity counter only runs inside a frame and restarts on every fall.
    if (state_q != ST_IDLE && !fall_stb)
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (fall_stb && !bit_val) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_stb) begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT)
            state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_stb) begin
          par_d   = bit_val;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_stb) begin
          state_d = ST_IDLE;
          if (!bit_val)
            frame_err_d = 1'b1;
          else if (!odd_parity_ok(shift_q, par_q))
            parity_err_d = 1'b1;
          else
            good_stb = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The last quiet cycle of the window ends the frame.
    if (state_q != ST_IDLE && !fall_stb && tmo_q == TMO_LAST) begin
      state_d     = ST_IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end
  end

  // Byte delivery, history and key decoding for a good byte; errors drop pending prefixes.
  always_comb begin
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    hist_d       = hist_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_valid_d  = 1'b0;
    overrun_d    = 1'b0;
    ext_d        = ext_q;
    brk_d        = brk_q;

    if (byte_valid_q && byte_ready)
      byte_valid_d = 1'b0;

    if (frame_err_d || parity_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    if (good_stb) begin
      hist_d = {hist_q[8*HIST_BYTES-1:0] << 8} | {{(8*HIST_BYTES-8){1'b0}}, shift_q};

      // A full holding register that is not being drained this cycle loses the new byte.
      if (!byte_valid_q || byte_ready) begin
        byte_data_d  = shift_q;
        byte_valid_d = 1'b1;
      end else begin
        overrun_d    = 1'b1;
      end

      // Key events never wait on the byte consumer.
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = shift_q;
        key_ext_d   = ext_q;
        key_break_d = brk_q;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end
    end
  end

  // All receiver state; reset aborts any frame in flight without raising a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      hist_q       <= '0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      hist_q       <= hist_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_valid_q  <= key_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign hist       = hist_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign key_valid  = key_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: stimulus pushes expected bytes, keys and
// error pulses computed from frame contents; a negedge monitor pops and compares.
module tb_ps2_rx_frame;

  localparam int DEB  = 4;
  localparam int TMO  = 200;
  localparam int HB   = 4;
  localparam int HALF = 40;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            kclk = 1'b1;
  logic            kdata = 1'b1;
  logic            byte_ready = 1'b1;
  logic [7:0]      byte_data;
  logic            byte_valid;
  logic [8*HB-1:0] hist;
  logic [7:0]      key_code;
  logic            key_ext, key_break, key_valid;
  logic            frame_err, parity_err, overrun;

  ps2_rx_frame #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .HIST_BYTES     (HB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kclk       (kclk),
    .kdata      (kdata),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .hist       (hist),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int ferr_cyc = -1;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Reference model state
  typedef struct { logic [7:0] code; logic ext; logic brk; } key_t;
  logic [7:0]      exp_bytes[$];
  key_t            exp_keys[$];
  logic [7:0]      exp_errs[$];
  logic [8*HB-1:0] m_hist = '0;
  bit              m_ext = 0, m_brk = 0, m_full = 0;
  int              exp_ovr = 0, got_ovr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endtask

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = ~(^d) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  // What a frame should produce, from the protocol rules alone.
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    key_t k;
    if (bad_stop || bad_par) begin
      exp_errs.push_back(bad_stop ? "F" : "P");
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_hist = (m_hist << 8) | {{(8*HB-8){1'b0}}, d};
      if (m_full && !byte_ready) exp_ovr++;
      else begin
        exp_bytes.push_back(d);
        m_full = !byte_ready;
      end
      if (d == 8'hE0) m_ext = 1;
      else if (d == 8'hF0) m_brk = 1;
      else begin
        k.code = d; k.ext = m_ext; k.brk = m_brk;
        exp_keys.push_back(k);
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  // Drives the first n wire bits; optional 2-cycle kclk glitches in each high phase.
  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      kdata = f[i];
      if (glitch) begin
        wcyc(5); kclk = 1'b0; wcyc(2); kclk = 1'b1; wcyc(HALF/2 - 7);
      end else wcyc(HALF/2);
      kclk = 1'b0;
      last_fall = cyc;
      wcyc(HALF);
      kclk = 1'b1;
      wcyc(HALF/2);
    end
    kdata = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit glitch);
    model_frame(d, bad_par, bad_stop);
    send_bits(mkframe(d, bad_par, bad_stop), 11, glitch);
    wcyc(20);
    chk("hist", hist, m_hist);
  endtask

  // Monitor: every DUT output event consumes one expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (byte_valid && byte_ready) begin
        if (exp_bytes.size() == 0) unexpected("byte");
        else chk("byte_data", byte_data, exp_bytes.pop_front());
      end
      if (key_valid) begin
        if (exp_keys.size() == 0) unexpected("key");
        else begin
          key_t k;
          k = exp_keys.pop_front();
          chk("key{code,ext,brk}", {key_code, key_ext, key_break}, {k.code, k.ext, k.brk});
        end
      end
      if (parity_err) begin
        if (exp_errs.size() == 0) unexpected("parity_err");
        else chk("parity_err", "P", exp_errs.pop_front());
      end
      if (frame_err) begin
        ferr_cyc = cyc;
        if (exp_errs.size() == 0) unexpected("frame_err");
        else chk("frame_err", "F", exp_errs.pop_front());
      end
      if (overrun) got_ovr++;
    end
  end

  initial begin
    int dly;
    logic [7:0] d;
    bit bp, bs;

    wcyc(3);
    chk("reset_outputs", {byte_data, byte_valid, hist, key_code, key_ext, key_break,
                          key_valid, frame_err, parity_err, overrun}, 64'd0);
    rst_n = 1'b1;
    wcyc(5);

    // Make code
    send_frame(8'h1C, 0, 0, 0);
    // Extended release
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h74, 0, 0, 0);
    chk("hist_e0f074", hist[23:0], 24'hE0F074);
    // Parity error, then release of a plain key
    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    // Bad stop bit
    send_frame(8'h1C, 0, 1, 0);
    // Partial frame then silence
    ferr_cyc = -1;
    exp_errs.push_back("F");
    m_ext = 0; m_brk = 0;
    send_bits(mkframe(8'h55, 0, 0), 5, 0);
    wcyc(260);
    dly = ferr_cyc - last_fall;
    checks++;
    if (ferr_cyc < 0 || dly < TMO || dly > TMO + 15) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles, expected %0d..%0d", dly, TMO, TMO + 15);
    end
    send_frame(8'h29, 0, 0, 0);

    // Back-pressure
    byte_ready = 1'b0;
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h32, 0, 0, 0);
    chk("hist_1c32", hist[15:0], 16'h1C32);
    chk("overrun_count", got_ovr, exp_ovr);
    chk("held_byte", {byte_valid, byte_data}, {1'b1, 8'h1C});
    @(posedge clk); #1;
    byte_ready = 1'b1;
    m_full = 0;
    @(negedge clk);
    @(negedge clk);
    chk("valid_drop", byte_valid, 1'b0);
    wcyc(5);

    // Glitches inside frames and on an idle bus
    send_frame(8'h5A, 0, 0, 1);
    send_frame(8'hE0, 0, 0, 1);
    repeat (3) begin
      kclk = 1'b0; wcyc(2); kclk = 1'b1; wcyc(10);
    end
    send_frame(8'h6B, 0, 0, 0);

    // Reset mid-frame
    send_bits(mkframe(8'h3C, 0, 0), 4, 0);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", {byte_data, byte_valid, hist, key_code, key_ext, key_break,
                           key_valid, frame_err, parity_err, overrun}, 64'd0);
    m_hist = '0; m_ext = 0; m_brk = 0; m_full = 0;
    kclk = 1'b1; kdata = 1'b1;
    wcyc(5);
    rst_n = 1'b1;
    wcyc(10);
    send_frame(8'h1C, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    d = 8'hE0;
        2:       d = 8'hF0;
        default: d = 8'($urandom);
      endcase
      bp = 0; bs = 0;
      case ($urandom_range(0, 7))
        0: bp = 1;
        1: bs = 1;
        default: ;
      endcase
      send_frame(d, bp, bs, 1'($urandom));
    end

    wcyc(50);
    chk("leftover_bytes", exp_bytes.size(), 0);
    chk("leftover_keys", exp_keys.size(), 0);
    chk("leftover_errs", exp_errs.size(), 0);
    chk("overrun_total", got_ovr, exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
